exe_div_unit: RTL and testbench
===============================

EXE_DIV_UNIT -- requirements
Module: exe_div_unit

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset: clk, rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous active-low reset.
REQ-004 start_EXE  input  1  a divide/remainder instruction occupies EXE; held high while the instruction is stalled in EXE.
REQ-005 div_op  input  2  operation code: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 rs1_data  input  32  dividend.
REQ-007 rs2_data  input  32  divisor.
REQ-008 flush_EXE  input  1  abort any in-flight operation.
REQ-009 stall_req  output  1  request to the hazard unit to freeze PC, IF/ID, ID/EX and EX/MEM.
REQ-010 busy  output  1  state is not IDLE.
REQ-011 done  output  1  result valid, one-cycle pulse.
REQ-012 result  output  32  quotient or remainder.

Function
REQ-013 The FSM SHALL have the states IDLE, CALC, FIX and DONE.
REQ-014 IDLE: if start_EXE=1 and flush_EXE=0, the block SHALL capture the operands and div_op on the next edge.
REQ-015 After capture, the FSM SHALL go to DONE if the operation is a special case, and to CALC with the counter at 0 otherwise.
REQ-016 CALC SHALL run one restoring iteration per cycle on operand magnitudes.
REQ-017 CALC SHALL run for exactly 32 cycles, with the counter going 0..31, and then go to FIX.
REQ-018 FIX SHALL apply the signs in one cycle and go to DONE.
REQ-019 Quotient sign SHALL be the XOR of the operand signs; remainder sign SHALL be the dividend sign.
REQ-020 Signs SHALL apply only to DIV and REM.
REQ-021 DONE SHALL assert done=1 for exactly one cycle and return to IDLE unconditionally.
REQ-022 start_EXE SHALL be ignored in the DONE cycle.
REQ-023 Normal latency: done SHALL be high in the 34th cycle after the capture edge, with the capture edge counted as edge 0.
REQ-024 Special-case latency: done SHALL be high in the cycle right after the capture edge.
REQ-025 Divide by zero SHALL give quotient 0xFFFFFFFF for both DIV and DIVU, and remainder rs1_data.
REQ-026 Signed overflow (0x80000000 / 0xFFFFFFFF, DIV/REM only) SHALL give quotient 0x80000000 and remainder 0.
REQ-027 stall_req SHALL be combinational: (IDLE and start_EXE and not flush_EXE) or CALC or FIX.
REQ-028 stall_req SHALL be 0 in DONE, so the pipeline advances on the done cycle.
REQ-029 result SHALL be registered, SHALL update only on entry to DONE, and SHALL hold until the next DONE.
REQ-030 flush_EXE=1 in any state SHALL force IDLE on the next edge, with no done pulse and result unchanged.
REQ-031 flush_EXE SHALL have priority over start_EXE.
REQ-032 stall_req SHALL be 0 in any cycle where flush_EXE=1.
REQ-033 Captured operands SHALL not change while busy=1; input changes during busy are ignored.
REQ-034 All arithmetic SHALL be 32-bit two's-complement.
REQ-035 The partial remainder SHALL be 33 bits wide; overflow SHALL be impossible by construction.

Reset
REQ-036 rst_n=0 at a clock edge SHALL force state IDLE, counter 0, result 0x00000000 and done 0.
REQ-037 Reset SHALL override flush_EXE and start_EXE.
REQ-038 Reset mid-operation SHALL discard the operation with no done pulse.
REQ-039 While rst_n=0, stall_req SHALL be 0 and busy SHALL be 0.

Structure
REQ-040 A shared package SHALL hold XLEN=32, DIV_ITER=32, the div_op encodings and the FSM state encoding.
REQ-041 One combinational sub-module, div_iter_step, SHALL implement a single restoring shift/subtract step.
REQ-042 div_iter_step inputs SHALL be the partial remainder, the quotient bits and the divisor magnitude.
REQ-043 div_iter_step outputs SHALL be the next partial remainder and the next quotient bits.

Verification
REQ-044 Test DIVU: rs1=100, rs2=7 -> stall_req high 34 cycles, done at edge 34, result 14; REMU with the same operands -> result 2.
REQ-045 Test DIV: rs1=-7 (0xFFFFFFF9), rs2=2 -> result 0xFFFFFFFD (-3); REM with the same operands -> 0xFFFFFFFF (-1).
REQ-046 Test special cases: DIV rs2=0 -> done 1 cycle after capture, result 0xFFFFFFFF; REM 0x80000000 by 0xFFFFFFFF -> result 0.
REQ-047 Test flush: assert flush_EXE at CALC counter 10 -> IDLE next edge, no done pulse, result unchanged, stall_req 0 in the flush cycle.
REQ-048 Test reset: rst_n=0 in FIX -> IDLE, result 0, done 0.
REQ-049 Test back-to-back: a new start_EXE in the cycle after DONE -> second capture with correct result, and no retrigger from the held start in DONE.

Source files
------------

// File: rtl/exe_div_unit_pkg.sv
// Shared definitions for the EXE-stage divide/remainder unit.
// Holds the data width, iteration count, div_op encodings, FSM state
// encoding and the conditional-negate helper used when applying signs.
package exe_div_unit_pkg;

  localparam int XLEN     = 32;
  localparam int DIV_ITER = 32;
  localparam int CNT_W    = $clog2(DIV_ITER);

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } div_state_e;

  // Two's-complement negate when neg is set, pass-through otherwise.
  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v,
                                               input logic            neg);
    return neg ? (~v + XLEN'(1)) : v;
  endfunction

endpackage

// File: rtl/exe_div_unit_step.sv
// div_iter_step: one restoring shift/subtract step on unsigned magnitudes.
// Ports:
//   rem_i  partial remainder (XLEN+1 bits)
//   quo_i  quotient bits; the MSB is the next dividend bit to shift in
//   dvs_i  divisor magnitude
//   rem_o  next partial remainder
//   quo_o  next quotient bits (new quotient bit enters at the LSB)
module div_iter_step
  import exe_div_unit_pkg::*;
(
  input  logic [XLEN:0]   rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] dvs_i,
  output logic [XLEN:0]   rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN+1:0] rem_sh;
  logic            ge;

  always_comb begin
    rem_sh = {rem_i, quo_i[XLEN-1]};
    ge     = (rem_sh >= {2'b00, dvs_i});
    if (ge) begin
      // The remainder stays below the divisor, so the difference fits in XLEN+1 bits.
      rem_o = (XLEN+1)'(rem_sh - {2'b00, dvs_i});
      quo_o = {quo_i[XLEN-2:0], 1'b1};
    end else begin
      rem_o = rem_sh[XLEN:0];
      quo_o = {quo_i[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/exe_div_unit.sv
// exe_div_unit: multi-cycle DIV/DIVU/REM/REMU unit for the EXE stage.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start_EXE         divide instruction present in EXE (held while stalled)
//   div_op            00 DIV, 01 DIVU, 10 REM, 11 REMU
//   rs1_data/rs2_data dividend / divisor
//   flush_EXE         abort any in-flight operation
//   stall_req         freeze request to the hazard unit
//   busy              FSM is not IDLE
//   done              one-cycle result-valid pulse
//   result            registered quotient or remainder
module exe_div_unit
  import exe_div_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_EXE,
  input  logic [1:0]      div_op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush_EXE,
  output logic            stall_req,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  div_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;

  logic [XLEN:0]   rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic            is_rem_q, is_rem_d;
  logic            q_neg_q, q_neg_d;
  logic            r_neg_q, r_neg_d;

  logic [XLEN:0]   step_rem;
  logic [XLEN-1:0] step_quo;

  logic            op_signed, a_neg, b_neg, div_zero, sgn_ovf;

  div_iter_step u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    is_rem_d = is_rem_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;

    op_signed = (div_op == OP_DIV) || (div_op == OP_REM);
    a_neg     = op_signed & rs1_data[XLEN-1];
    b_neg     = op_signed & rs2_data[XLEN-1];
    div_zero  = (rs2_data == '0);
    sgn_ovf   = op_signed && (rs1_data == {1'b1, {(XLEN-1){1'b0}}})
                          && (rs2_data == '1);

    case (state_q)
      ST_IDLE: begin
        if (start_EXE) begin
          is_rem_d = div_op[1];
          q_neg_d  = a_neg ^ b_neg;
          r_neg_d  = a_neg;
          rem_d    = '0;
          quo_d    = cond_neg(rs1_data, a_neg);
          dvs_d    = cond_neg(rs2_data, b_neg);
          cnt_d    = '0;
          // Special cases resolve at capture and skip the iteration loop.
          if (div_zero) begin
            result_d = div_op[1] ? rs1_data : '1;
            state_d  = ST_DONE;
          end else if (sgn_ovf) begin
            result_d = div_op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
            state_d  = ST_DONE;
          end else begin
            state_d  = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DIV_ITER - 1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        result_d = is_rem_q ? cond_neg(rem_q[XLEN-1:0], r_neg_q)
                            : cond_neg(quo_q, q_neg_q);
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Flush wins over everything, including a capture in IDLE.
    if (flush_EXE) begin
      state_d  = ST_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // Datapath registers carry no reset; they are always loaded at capture.
  always_ff @(posedge clk) begin
    rem_q    <= rem_d;
    quo_q    <= quo_d;
    dvs_q    <= dvs_d;
    is_rem_q <= is_rem_d;
    q_neg_q  <= q_neg_d;
    r_neg_q  <= r_neg_d;
  end

  assign stall_req = rst_n & ~flush_EXE &
                     (((state_q == ST_IDLE) & start_EXE) |
                      (state_q == ST_CALC) | (state_q == ST_FIX));
  assign busy      = rst_n & (state_q != ST_IDLE);
  assign done      = rst_n & (state_q == ST_DONE);
  assign result    = result_q;

endmodule

// File: tb/tb_exe_div_unit.sv
module tb_exe_div_unit;
  import exe_div_unit_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start_EXE;
  logic [1:0]  div_op;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush_EXE;
  logic        stall_req;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  exe_div_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_EXE (start_EXE),
    .div_op    (div_op),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .flush_EXE (flush_EXE),
    .stall_req (stall_req),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    int          stalls;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    start_EXE = 1'b0;
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the DONE cycle with
  // start_EXE still high, so a caller may chain a back-to-back op.
  task automatic run_op(input string nm, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp,
                        input int exp_lat, input int exp_stalls);
    int lat;
    int stalls;
    bit got;
    start_EXE = 1'b1;
    div_op    = op;
    rs1_data  = a;
    rs2_data  = b;
    #1;
    stalls = stall_req ? 1 : 0;
    @(posedge clk);
    lat = 0;
    got = 0;
    while (!got && lat < 60) begin
      @(negedge clk);
      lat++;
      if (done) got = 1;
      else if (stall_req) stalls++;
      // Operands must be ignored while busy and start must be ignored in DONE.
      rs1_data = $urandom;
      rs2_data = $urandom;
      div_op   = 2'($urandom_range(0, 3));
    end
    chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, "_result"}, result, exp);
    chk({nm, "_stall_cycles"}, 32'(stalls), 32'(exp_stalls));
    @(negedge clk);
    chk({nm, "_no_retrigger"}, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    logic [31:0] prev;
    bit seen;

    vecs[0]  = '{OP_DIVU, 32'd100,        32'd7,          32'd14,         34, 34};
    vecs[1]  = '{OP_REMU, 32'd100,        32'd7,          32'd2,          34, 34};
    vecs[2]  = '{OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34, 34};
    vecs[3]  = '{OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34, 34};
    vecs[4]  = '{OP_DIV,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  1,  1};
    vecs[5]  = '{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1,  1};
    vecs[6]  = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1,  1};
    vecs[7]  = '{OP_DIVU, 32'd7,          32'd0,          32'hFFFF_FFFF,  1,  1};
    vecs[8]  = '{OP_REMU, 32'd7,          32'd0,          32'd7,          1,  1};
    vecs[9]  = '{OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          34, 34};
    vecs[10] = '{OP_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  34, 34};
    vecs[11] = '{OP_DIV,  32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  34, 34};
    vecs[12] = '{OP_REM,  32'd100,        32'hFFFF_FFF9,  32'd2,          34, 34};
    vecs[13] = '{OP_REM,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  34, 34};
    vecs[14] = '{OP_DIV,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         34, 34};
    vecs[15] = '{OP_REM,  32'h8000_0000,  32'd0,          32'h8000_0000,  1,  1};

    rst_n     = 1'b0;
    start_EXE = 1'b0;
    flush_EXE = 1'b0;
    div_op    = OP_DIVU;
    rs1_data  = 32'd100;
    rs2_data  = 32'd7;

    // Reset with start asserted: reset must dominate.
    @(negedge clk);
    start_EXE = 1'b1;
    #1;
    chk("reset_stall_req", {31'd0, stall_req}, 32'd0);
    @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    start_EXE = 1'b0;
    rst_n     = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      run_op($sformatf("v%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp,
             vecs[i].lat, vecs[i].stalls);
      idle();
    end

    // Back-to-back: second start in the cycle right after DONE.
    run_op("b2b_first", OP_DIVU, 32'd100, 32'd7, 32'd14, 34, 34);
    run_op("b2b_second", OP_REMU, 32'd100, 32'd7, 32'd2, 34, 34);
    idle();

    // Flush while CALC counter is 10.
    prev      = result;
    start_EXE = 1'b1;
    div_op    = OP_DIVU;
    rs1_data  = 32'd1000;
    rs2_data  = 32'd3;
    @(posedge clk);
    repeat (11) @(negedge clk);
    chk("flush_busy_before", {31'd0, busy}, 32'd1);
    flush_EXE = 1'b1;
    #1;
    chk("flush_stall_req", {31'd0, stall_req}, 32'd0);
    @(negedge clk);
    chk("flush_idle", {31'd0, busy}, 32'd0);
    chk("flush_done", {31'd0, done}, 32'd0);
    chk("flush_prio_stall", {31'd0, stall_req}, 32'd0);
    chk("flush_result_held", result, prev);
    @(negedge clk);
    chk("flush_prio_busy", {31'd0, busy}, 32'd0);
    flush_EXE = 1'b0;
    start_EXE = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done || busy) seen = 1;
    end
    chk("flush_no_done", {31'd0, seen}, 32'd0);
    chk("flush_result_after", result, prev);

    // Reset asserted while in FIX.
    start_EXE = 1'b1;
    div_op    = OP_DIVU;
    rs1_data  = 32'd100;
    rs2_data  = 32'd7;
    @(posedge clk);
    repeat (33) @(negedge clk);
    chk("fix_busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("fix_rst_stall", {31'd0, stall_req}, 32'd0);
    chk("fix_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("fix_rst_result", result, 32'd0);
    chk("fix_rst_done", {31'd0, done}, 32'd0);
    start_EXE = 1'b0;
    rst_n     = 1'b1;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done || busy) seen = 1;
    end
    chk("fix_rst_no_done", {31'd0, seen}, 32'd0);
    chk("fix_rst_result_after", result, 32'd0);

    // Unit still works after the reset.
    run_op("post_reset", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 34);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
